// File: rtl/jk_bank_sched_if.sv
// Requester command channel for jk_bank_sched: valid/ready handshake plus
// the operation, bit mask and COUNT length carried with each command.
interface jk_bank_sched_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CW    = 8
);
  logic             valid;
  logic             ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] mask;
  logic [CW-1:0]    cnt;

  modport master (output valid, output op, output mask, output cnt, input ready);
  modport slave  (input valid, input op, input mask, input cnt, output ready);
endinterface

// File: rtl/jk_bank_sched.sv
// Round-robin scheduler for a bank of WIDTH JK flip-flops shared by two
// requesters. SET/CLEAR/HOLD apply one J/K vector for a cycle; COUNT runs the
// bank as a JK-toggle binary up-counter for a programmed number of clocks.
module jk_bank_sched #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  jk_bank_sched_if.slave   req0,
  jk_bank_sched_if.slave   req1,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             busy,
  output logic [1:0]       owner,
  output logic             wrap
);

  localparam logic [1:0] OP_HOLD  = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_COUNT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_COUNT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_j;
  logic [WIDTH-1:0] r_k;
  logic [CW-1:0]    r_rem;
  logic             r_last;   // 1: last grant went to req1, so req0 is favoured
  logic             r_busy;
  logic             r_wrap;
  logic [1:0]       r_owner;

  logic             w_grant0;
  logic             w_grant1;
  logic             w_accept;
  logic [1:0]       w_op;
  logic [WIDTH-1:0] w_mask;
  logic [CW-1:0]    w_cnt;
  logic [WIDTH-1:0] w_tog;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic [WIDTH-1:0] w_q_next;

  // Arbitration: only in IDLE and never while reset is asserted
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if ((r_state == S_IDLE) && !rst) begin
      w_grant0 = req0.valid && (!req1.valid || r_last);
      w_grant1 = req1.valid && (!req0.valid || !r_last);
    end
  end

  assign req0.ready = w_grant0;
  assign req1.ready = w_grant1;
  assign w_accept   = w_grant0 | w_grant1;
  assign w_op       = w_grant1 ? req1.op   : req0.op;
  assign w_mask     = w_grant1 ? req1.mask : req0.mask;
  assign w_cnt      = w_grant1 ? req1.cnt  : req0.cnt;

  // Counter toggle enables: bit i toggles when all lower bits are one
  always_comb begin
    logic w_carry;
    w_tog   = '0;
    w_carry = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_tog[i] = w_carry;
      w_carry  = w_carry & r_q[i];
    end
  end

  // Next state and the J/K vector presented to the bank this cycle
  always_comb begin
    w_next_state = r_state;
    w_j          = '0;
    w_k          = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = ((w_op == OP_COUNT) && (w_cnt != '0)) ? S_COUNT : S_APPLY;
        end
      end
      S_APPLY: begin
        w_j          = r_j;
        w_k          = r_k;
        w_next_state = S_IDLE;
      end
      S_COUNT: begin
        w_j = w_tog;
        w_k = w_tog;
        if (r_rem == CW'(1)) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
    // JK characteristic equation applied per bit
    w_q_next = (w_j & ~r_q) | (~w_k & r_q);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Bank, captured command, counters and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q     <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_rem   <= '0;
      r_last  <= 1'b1;
      r_owner <= '0;
      r_busy  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_q    <= w_q_next;
      r_busy <= (w_next_state != S_IDLE);
      r_wrap <= (r_state == S_COUNT) && (&r_q);
      if (r_state == S_COUNT) begin
        r_rem <= r_rem - CW'(1);
      end
      if (w_accept) begin
        r_owner <= {w_grant1, w_grant0};
        r_last  <= w_grant1;
        // HOLD and COUNT (including COUNT 0) leave J=K=0
        r_j     <= (w_op == OP_SET)   ? w_mask : '0;
        r_k     <= (w_op == OP_CLEAR) ? w_mask : '0;
        if (w_op == OP_COUNT) begin
          r_rem <= w_cnt;
        end
      end else if (w_next_state == S_IDLE) begin
        r_owner <= '0;
      end
    end
  end

  assign q     = r_q;
  assign qbar  = ~r_q;
  assign busy  = r_busy;
  assign owner = r_owner;
  assign wrap  = r_wrap;

endmodule

// File: tb/tb_jk_bank_sched.sv
// Scoreboard bench for jk_bank_sched: a transaction-level model predicts
// arbitration and the bank value; a monitor checks each busy period.
module tb_jk_bank_sched;
  localparam int unsigned W    = 4;
  localparam int unsigned CW   = 8;
  localparam int unsigned MASK = (1 << W) - 1;
  localparam logic [1:0] OP_HOLD  = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_COUNT = 2'b11;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] q;
  logic [W-1:0] qbar;
  logic         busy;
  logic [1:0]   owner;
  logic         wrap;

  jk_bank_sched_if #(.WIDTH(W), .CW(CW)) req0 ();
  jk_bank_sched_if #(.WIDTH(W), .CW(CW)) req1 ();

  jk_bank_sched #(.WIDTH(W), .CW(CW)) dut (
    .clk   (clk),
    .rst   (rst),
    .req0  (req0),
    .req1  (req1),
    .q     (q),
    .qbar  (qbar),
    .busy  (busy),
    .owner (owner),
    .wrap  (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  owner;
    int unsigned start;
    bit          is_cnt;
    int unsigned q;
    int unsigned cycles;
    int unsigned wraps;
  } exp_t;

  exp_t sb[$];
  int unsigned tests = 0;
  int unsigned fails = 0;

  // Reference model state
  int unsigned m_q;
  int unsigned m_left;
  bit          m_last;
  // Pending command per requester (held until accepted)
  bit          p_v[2];
  logic [1:0]  p_op[2];
  int unsigned p_mask[2];
  int unsigned p_cnt[2];
  int          mode;   // 0 random, 1 contention refill, 2 no new commands

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_pins();
    req0.valid = p_v[0];
    req0.op    = p_op[0];
    req0.mask  = W'(p_mask[0]);
    req0.cnt   = CW'(p_cnt[0]);
    req1.valid = p_v[1];
    req1.op    = p_op[1];
    req1.mask  = W'(p_mask[1]);
    req1.cnt   = CW'(p_cnt[1]);
  endtask

  task automatic set_cmd(input int n, input logic [1:0] op, input int unsigned mask,
                         input int unsigned cnt);
    p_v[n] = 1'b1; p_op[n] = op; p_mask[n] = mask; p_cnt[n] = cnt;
  endtask

  // Model the effect of a granted command and push its expected outcome
  task automatic accept(input int n);
    exp_t e;
    e.owner  = (n == 1) ? 2'b10 : 2'b01;
    e.start  = m_q;
    e.is_cnt = 1'b0;
    e.cycles = 1;
    e.wraps  = 0;
    case (p_op[n])
      OP_SET:   m_q = (m_q | p_mask[n]) & MASK;
      OP_CLEAR: m_q = m_q & ~p_mask[n] & MASK;
      OP_COUNT: if (p_cnt[n] > 0) begin
        e.is_cnt = 1'b1;
        e.cycles = p_cnt[n];
        e.wraps  = (m_q + p_cnt[n]) >> W;
        m_q      = (m_q + p_cnt[n]) & MASK;
      end
      default: ;
    endcase
    e.q = m_q;
    sb.push_back(e);
    m_left = e.cycles;
    m_last = (n == 1);
    p_v[n] = 1'b0;
  endtask

  // One clock of stimulus: refill, drive, check readies against the model
  task automatic cycle();
    bit idle, g0, g1;
    @(negedge clk);
    for (int n = 0; n < 2; n++) begin
      if (!p_v[n]) begin
        if (mode == 1) begin
          set_cmd(n, (n == 0) ? OP_SET : OP_CLEAR, 4'b1000, 0);
        end else if (mode == 0 && $urandom_range(0, 1) == 1) begin
          set_cmd(n, 2'($urandom_range(0, 3)), $urandom_range(0, MASK),
                  ($urandom_range(0, 7) == 0) ? $urandom_range(7, 20) : $urandom_range(0, 6));
        end
      end
    end
    drive_pins();
    #1;
    idle = (m_left == 0);
    g0 = idle && p_v[0] && (!p_v[1] || m_last);
    g1 = idle && p_v[1] && (!p_v[0] || !m_last);
    check("ready0", req0.ready, g0);
    check("ready1", req1.ready, g1);
    if (m_left > 0) m_left--;
    if (g0) accept(0);
    else if (g1) accept(1);
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    mode = 2;
    while ((m_left != 0 || p_v[0] || p_v[1]) && n < 200) begin
      cycle();
      n++;
    end
    check("idle_bound", (n < 200) ? 1 : 0, 1);
    repeat (2) cycle();
  endtask

  task automatic issue(input int n, input logic [1:0] op, input int unsigned mask,
                       input int unsigned cnt);
    set_cmd(n, op, mask, cnt);
    wait_idle();
  endtask

  // Asynchronous reset asserted mid-cycle, released just before a falling edge
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    sb.delete();
    m_q = 0; m_left = 0; m_last = 1'b1;
    drive_pins();
    #1;
    check("rst_q", q, 0);
    check("rst_qbar", qbar, MASK);
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 0);
    check("rst_ready0", req0.ready, 0);
    check("rst_ready1", req1.ready, 0);
    repeat (2) @(negedge clk);
    check("rst_ready0_hold", req0.ready, 0);
    check("rst_ready1_hold", req1.ready, 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  // Monitor: checks every busy cycle and the outcome of each completed command
  initial begin
    bit          act = 1'b0;
    int unsigned cyc = 0;
    int unsigned wr  = 0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        act = 1'b0;
      end else begin
        check("qbar", qbar, ~q & MASK);
        if (busy) begin
          if (!act) begin
            act = 1'b1; cyc = 0; wr = 0;
          end
          cyc++;
          if (wrap) wr++;
          if (sb.size() == 0) begin
            check("sb_has_entry", 0, 1);
          end else begin
            e = sb[0];
            check("busy_owner", owner, e.owner);
            check("busy_q", q, e.is_cnt ? ((e.start + cyc - 1) & MASK) : e.start);
          end
        end else if (act) begin
          act = 1'b0;
          if (wrap) wr++;
          if (sb.size() == 0) begin
            check("sb_has_entry", 0, 1);
          end else begin
            e = sb.pop_front();
            check("done_q", q, e.q);
            check("done_cycles", cyc, e.cycles);
            check("done_wraps", wr, e.wraps);
            check("done_owner", owner, 0);
          end
        end else begin
          check("idle_wrap", wrap, 0);
          check("idle_owner", owner, 0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    mode = 2;
    for (int n = 0; n < 2; n++) begin
      p_v[n] = 1'b0; p_op[n] = OP_HOLD; p_mask[n] = 0; p_cnt[n] = 0;
    end
    m_q = 0; m_left = 0; m_last = 1'b1;
    drive_pins();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;

    // Random warm-up, then reset with req0 SET 0101 pending
    mode = 0;
    repeat (40) cycle();
    mode = 2;
    p_v[1] = 1'b0;
    set_cmd(0, OP_SET, 4'b0101, 0);
    do_reset();
    wait_idle();
    check("reset_then_set_q", q, 4'b0101);

    // Contention: both valid continuously
    mode = 1;
    repeat (12) cycle();
    wait_idle();

    // COUNT 3 from 1110 wraps once
    issue(0, OP_CLEAR, MASK, 0);
    issue(0, OP_SET, 4'b1110, 0);
    issue(0, OP_COUNT, 0, 3);
    check("count_wrap_q", q, 4'b0001);

    // COUNT 0 behaves as HOLD
    issue(1, OP_CLEAR, MASK, 0);
    issue(1, OP_SET, 4'b0011, 0);
    issue(1, OP_COUNT, 0, 0);
    check("count0_q", q, 4'b0011);

    // Stall: req1 SET during req0 COUNT 5
    issue(0, OP_CLEAR, MASK, 0);
    set_cmd(0, OP_COUNT, 0, 5);
    cycle();
    set_cmd(1, OP_SET, 4'b0001, 0);
    wait_idle();
    check("stall_q", q, 4'b0101);

    // Reset after 4 increments of COUNT 10
    issue(0, OP_CLEAR, MASK, 0);
    set_cmd(0, OP_COUNT, 0, 10);
    cycle();
    repeat (4) cycle();
    do_reset();
    mode = 2;
    repeat (6) cycle();
    check("post_reset_q", q, 0);
    check("post_reset_busy", busy, 0);

    // Long random run
    mode = 0;
    repeat (400) cycle();
    wait_idle();
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jk_bank_sched.md
# jk_bank_sched

Round-robin scheduler and sequencer for a shared bank of WIDTH JK flip-flops, modelled behaviourally inside the block. Two requesters issue SET, CLEAR, HOLD or COUNT commands to the bank through a valid/ready handshake. The block arbitrates between them and drives the per-bit J/K vectors. COUNT runs the bank as a synchronous binary up-counter built from JK toggle equations for a programmed number of clocks.

## Interface
- WIDTH, 4: number of JK flip-flops in the bank (legal range 2–16).
- CW, 8: width of the COUNT length field.

- clk  input  1: clock; all state changes on the rising edge.
- rst  input  1: reset, asynchronous, active-high.
- req0_valid  input  1: requester 0 has a command.
- req0_ready  output  1: requester 0 command accepted this edge if valid.
- req0_op  input  2: 00 HOLD, 01 SET, 10 CLEAR, 11 COUNT.
- req0_mask  input  WIDTH: bits affected by SET/CLEAR (ignored for HOLD/COUNT).
- req0_cnt  input  CW: COUNT length in clocks (ignored for other ops).
- req1_valid, req1_ready, req1_op, req1_mask, req1_cnt: same as requester 0.
- q  output  WIDTH: bank state.
- qbar  output  WIDTH: always ~q.
- busy  output  1: high when state is not IDLE.
- owner  output  2: one-hot owner of the command in progress; 00 in IDLE.
- wrap  output  1: one-cycle pulse when COUNT rolls q from all-ones to zero.

## Operation
- **States**
  - IDLE: accepts commands.
  - APPLY: applies one J/K vector for one cycle.
  - COUNT: counts while remaining > 0.
- **Arbitration**
  - Arbitration happens only in IDLE. reqN_ready is combinational and equals (state==IDLE) && (N is the winner).
  - If only one requester is valid, it wins.
  - If both are valid, the requester not granted last wins. A pointer holds the last grant; after reset it favours req0.
  - ready is never high for both requesters at once. ready is never high outside IDLE.
- **Acceptance (handshake edge)**
  - owner is set to the winner. The pointer is updated.
  - SET: j_vec = mask, k_vec = 0. Next state APPLY.
  - CLEAR: j_vec = 0, k_vec = mask. Next state APPLY.
  - HOLD: j_vec = k_vec = 0. Next state APPLY.
  - COUNT with cnt=0: treated as HOLD (APPLY, no change).
  - COUNT with cnt>0: remaining = cnt. Next state COUNT.
- **APPLY edge**
  - Per bit: J=0,K=0 → hold; 1,0 → 1; 0,1 → 0; 1,1 → toggle.
  - Next state IDLE. owner is cleared.
- **COUNT edge**
  - Bit i gets J=K=AND(q[i-1:0]); bit 0 gets J=K=1. Net effect: q <= q+1 mod 2^WIDTH.
  - remaining is decremented.
  - If remaining was 1: next state IDLE and owner is cleared.
  - wrap is registered and high for the cycle after the edge where q goes from all-ones to 0.
- **Registered outputs**
  - q, busy, owner and wrap are registered. qbar is derived from q.
- **Reset (asserted at any time, including mid-COUNT)**
  - State IDLE. q=0, qbar=all ones, busy=0, owner=00, wrap=0.
  - remaining=0. Pointer favours req0.
  - The interrupted command is discarded. No ready is given while rst is high.

## Timing
- SET/CLEAR/HOLD:
  - Accept at edge E0. q updates at E1. IDLE again at E1.
  - Minimum spacing between acceptances is 2 clocks.
- COUNT N (N≥1):
  - Accept at E0. q increments at E1..EN. IDLE at EN.
  - Next acceptance possible at EN+1.
- busy is high from E0 to the closing edge, exclusive.
- Commands presented while busy stall: valid is held and ready stays low. There is no queueing.
- Request inputs are sampled only on the handshake edge. Later changes do not affect the command in progress.

## Test plan
- **Reset:** assert rst mid-cycle, async. Required: q=0000, qbar=1111, busy=0, owner=00, both readies 0 while rst is high. Release rst with req0 SET mask=0101 pending. Required: accepted at the first edge, q=0101 one edge later.
- **Contention:** req0 and req1 both valid continuously. req0 SET 1000, req1 CLEAR 1000, repeated. Required: grants alternate req0, req1, req0. q toggles 1000 → 0000 → 1000 every 2 clocks. ready is never high for both.
- **COUNT with wrap:** from q=1110, COUNT cnt=3. Required: q=1111, 0000, 0001 on three successive edges. wrap pulses once, in the cycle after 1111→0000. busy high for exactly 3 cycles.
- **Degenerate COUNT:** COUNT cnt=0 from q=0011. Required: q stays 0011, busy high for 1 cycle, then IDLE.
- **Stall:** req1 asserts SET 0001 during req0 COUNT cnt=5. Required: req1_ready stays low for 5 cycles. req1 is accepted on the edge after COUNT ends. The bit set is OR-ed into the counted value.
- **Reset mid-COUNT:** req0 COUNT cnt=10 from 0000, assert rst after 4 increments. Required: immediate q=0000, busy=0. After release, no resumed counting.
